// File: rtl/dds_sample_engine.sv
// rtl/dds_sample_engine.sv - phase-accumulator sample sequencer driving sine ROM address and DAC load strobe
module dds_sample_engine #(
    parameter int DIV_TC  = 4999,
    parameter int ACC_W   = 20,
    parameter int ADDR_W  = 10,
    parameter int FREQ_W  = 10,
    parameter int ROM_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              enable,
    input  logic [FREQ_W-1:0] freq_word,
    input  logic              dac_busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              load,
    output logic              sample_tick,
    output logic [7:0]        overrun_cnt
);
    localparam int DIV_W  = (DIV_TC < 1) ? 1 : $clog2(DIV_TC + 1);
    localparam int WAIT_W = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);
    localparam logic [DIV_W-1:0]  DIV_TC_V  = DIV_W'(DIV_TC);
    localparam logic [WAIT_W-1:0] ROM_LAT_V = WAIT_W'(ROM_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              tick;
    logic              tick_drop;
    logic              busy_drop;
    logic [8:0]        ovr_sum;

    assign tick        = enable && (div_cnt == DIV_TC_V);
    assign sample_tick = tick;
    assign acc_next    = acc + ACC_W'(freq_word);

    // A tick outside IDLE and a LOAD cycle blocked by the DAC both cost one sample
    assign tick_drop = tick && (state != IDLE);
    assign busy_drop = (state == LOAD) && dac_busy;
    assign load      = (state == LOAD) && !dac_busy;
    assign ovr_sum   = {1'b0, overrun_cnt} + 9'(tick_drop) + 9'(busy_drop);

    // Sample-rate divider: held at zero while disabled so re-enable restarts a full period
    always_ff @(posedge CLOCK_50) begin
        if (RESET || !enable || (div_cnt == DIV_TC_V)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Saturating dropped-sample counter
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            overrun_cnt <= '0;
        end else if (ovr_sum[8]) begin
            overrun_cnt <= 8'hFF;
        end else begin
            overrun_cnt <= ovr_sum[7:0];
        end
    end

    // Frame sequencer: advance phase on tick, wait out ROM latency, then offer the sample
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state    <= IDLE;
            acc      <= '0;
            rom_addr <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        acc      <= acc_next;
                        rom_addr <= acc_next[ACC_W-1 -: ADDR_W];
                        wait_cnt <= ROM_LAT_V;
                        state    <= (ROM_LAT == 0) ? LOAD : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
